// File: rtl/wb_data_arbiter.sv
// Two-master Wishbone B4 arbiter: round-robin grant held for the whole CYC window.
// Optional hung-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_data_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        M0_CYC,
    input  logic        M0_STB,
    input  logic        M0_WE,
    input  logic [31:0] M0_ADR,
    input  logic [31:0] M0_DAT_O,
    input  logic [2:0]  M0_CTI_O,
    output logic        M0_ACK,
    output logic        M0_ERR,
    output logic        M0_RTY,
    output logic [31:0] M0_DAT_I,

    input  logic        M1_CYC,
    input  logic        M1_STB,
    input  logic        M1_WE,
    input  logic [31:0] M1_ADR,
    input  logic [31:0] M1_DAT_O,
    input  logic [2:0]  M1_CTI_O,
    output logic        M1_ACK,
    output logic        M1_ERR,
    output logic        M1_RTY,
    output logic [31:0] M1_DAT_I,

    output logic        S_CYC,
    output logic        S_STB,
    output logic        S_WE,
    output logic [31:0] S_ADR,
    output logic [31:0] S_DAT_O,
    output logic [2:0]  S_CTI_O,
    input  logic        S_ACK,
    input  logic        S_ERR,
    input  logic        S_RTY,
    input  logic [31:0] S_DAT_I,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic        mux_cyc, mux_stb;
    logic        wd_err;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC && M1_CYC) state_d = last_q ? GNT0 : GNT1;
                else if (M0_CYC)      state_d = GNT0;
                else if (M1_CYC)      state_d = GNT1;
            end
            GNT0: begin
                if (!M0_CYC) begin
                    last_d  = 1'b0;
                    state_d = M1_CYC ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!M1_CYC) begin
                    last_d  = 1'b1;
                    state_d = M0_CYC ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = {state_d == GNT1, state_d == GNT0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Ownership comes from the registered grant, so a same-cycle CYC drop still sees its ACK.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        S_WE    = 1'b0;
        S_ADR   = '0;
        S_DAT_O = '0;
        S_CTI_O = '0;
        if (grant_q[0]) begin
            mux_cyc = M0_CYC;
            mux_stb = M0_STB;
            S_WE    = M0_WE;
            S_ADR   = M0_ADR;
            S_DAT_O = M0_DAT_O;
            S_CTI_O = M0_CTI_O;
        end else if (grant_q[1]) begin
            mux_cyc = M1_CYC;
            mux_stb = M1_STB;
            S_WE    = M1_WE;
            S_ADR   = M1_ADR;
            S_DAT_O = M1_DAT_O;
            S_CTI_O = M1_CTI_O;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        wd_err_q, wd_err_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_err_d = 1'b0;
        if ((grant_d != grant_q) || S_ACK || S_ERR || S_RTY || wd_err_q) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == TIMEOUT_LIMIT) begin
            wd_cnt_d = '0;
            wd_err_d = 1'b1;
        end else if (mux_cyc && mux_stb) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_LIMIT;
    assign wd_err         = 1'b0;
`endif

    // The watchdog pulse abandons the slave cycle for one clock.
    assign S_CYC = mux_cyc & ~wd_err;
    assign S_STB = mux_stb & ~wd_err;

    assign M0_ACK   = S_ACK & grant_q[0];
    assign M0_ERR   = (S_ERR | wd_err) & grant_q[0];
    assign M0_RTY   = S_RTY & grant_q[0];
    assign M1_ACK   = S_ACK & grant_q[1];
    assign M1_ERR   = (S_ERR | wd_err) & grant_q[1];
    assign M1_RTY   = S_RTY & grant_q[1];
    assign M0_DAT_I = S_DAT_I;
    assign M1_DAT_I = S_DAT_I;

    assign grant = grant_q;

endmodule

// File: doc/wb_data_arbiter.md
# wb_data_arbiter

Two-master Wishbone B4 arbiter that shares the single data-side slave bus between the instruction fetch unit (master 0) and the `memory_access` load/store unit (master 1). It grants the bus round-robin, holds each grant for the whole `CYC` window, muxes the request signals onto the slave side, and routes `ACK`/`ERR`/`RTY` back only to the granted master. An optional watchdog converts a hung slave cycle into an `ERR` response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stall limit used by the watchdog. Legal range is 1..65535.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `M0_CYC`, `M0_STB`, `M0_WE` in 1 each: fetch master bus cycle, strobe and write enable.
- `M0_ADR`, `M0_DAT_O` in 32 each: fetch master address and write data.
- `M0_CTI_O` in 3: fetch master cycle type.
- `M0_ACK`, `M0_ERR`, `M0_RTY` out 1 each: responses to the fetch master.
- `M0_DAT_I` out 32: read data to the fetch master.
- `M1_*`: same set of ports as `M0_*`, for the `memory_access` master.
- `S_CYC`, `S_STB`, `S_WE` out 1 each: slave-side bus cycle, strobe and write enable.
- `S_ADR`, `S_DAT_O` out 32 each: slave-side address and write data.
- `S_CTI_O` out 3: slave-side cycle type.
- `S_ACK`, `S_ERR`, `S_RTY` in 1 each: slave responses.
- `S_DAT_I` in 32: slave read data.
- `grant` out 2: one-hot current owner. `01` is M0, `10` is M1, `00` is idle. Provided for debug and for the control unit.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`. Register `last` records the last served master.
- `IDLE`:
  - Only M0_CYC set → `GNT0`.
  - Only M1_CYC set → `GNT1`.
  - Both set → grant the master not equal to `last`.
  - Neither set → stay in `IDLE`.
- `GNTn`:
  - Hold while `Mn_CYC`=1.
  - When `Mn_CYC`=0 and the other master's CYC=1 → go directly to the other `GNT` state.
  - When `Mn_CYC`=0 and no other request → `IDLE`.
  - `last` is updated to n on every exit from `GNTn`.
- Slave request side:
  - `S_CYC` = `Mn_CYC` of the owner; `S_STB` = `Mn_STB` of the owner.
  - `S_ADR`, `S_DAT_O`, `S_WE`, `S_CTI_O` are muxed from the owner.
  - In `IDLE` all slave request outputs are 0.
- Response side:
  - `Mn_ACK/ERR/RTY` = `S_ACK/ERR/RTY` & owner==n. A non-owner never sees a response.
  - `S_DAT_I` is broadcast to both `Mn_DAT_I`.
- Locked cycles: a master holding CYC across several STB beats (burst, CTI≠000) is never preempted.

## Timing
- Grant latency: the `grant` register changes on the edge after CYC is seen. `S_CYC` follows the owner combinationally in the same cycle the grant is visible. Minimum request-to-`S_CYC` latency is 1 cycle.
- Handover: the owner drops CYC in cycle t; the other master's `S_CYC` is asserted in cycle t+1. There is no dead cycle.
- Simultaneous first requests after reset: `last` resets to 1, so M0 wins.
- Master drops CYC in the same cycle `S_ACK` arrives: the ACK is still routed to that master, because ownership changes only at the following edge.
- Reset mid-cycle: with `rst`=0 at an edge, the next state is `IDLE`, `last`=1, `grant`=00, and all S_* request outputs and all M*_ACK/ERR/RTY are 0. The in-flight transfer is abandoned with no response.
- Reset values: `grant`=00 and all other outputs 0, except `M*_DAT_I`, which follows `S_DAT_I`.

## Configuration
- Macro `WB_ARB_TIMEOUT_EN`.
- Defined: a 16-bit counter increments each cycle in which `S_CYC&S_STB` is set and no `S_ACK/ERR/RTY` is present. It clears on any response, on grant change, or on reset.
- When the count equals `TIMEOUT_CYCLES`, the arbiter does the following in the next cycle:
  - Drives the owner's `Mn_ERR`=1 for exactly one cycle.
  - Forces `S_CYC`=`S_STB`=0 for that same cycle.
  - Clears the counter.
- The grant is kept until the owner drops CYC.
- Undefined: no counter is built, and `M*_ERR` reflects only `S_ERR`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with M0_CYC=M1_CYC=1 → `grant`=00, `S_CYC`=0, all ACKs 0.
- Single M1 load: M1_CYC=STB=1, ADR=0x0000_0104, slave ACKs after 2 cycles with `S_DAT_I`=0xDEADBEEF → `grant`=10 one cycle after the request, M1_ACK=1 with M1_DAT_I=0xDEADBEEF, M0_ACK stays 0.
- Contention: both masters request in the same cycle after reset → M0 is served first. After M0 drops CYC, `grant`=10 on the very next cycle. A second contention then grants M0 again.
- Burst lock: M0 runs 4 beats with CTI=010 while M1_CYC=1 throughout → `grant` stays 01 for all 4 ACKs, then switches to 10.
- Mid-transfer reset: M1 is granted and waiting for ACK, and `rst`=0 for 1 cycle → `grant`=00 next cycle and M1 receives no ACK.
- Timeout (with `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): the slave never responds → M0_ERR pulses for exactly 1 cycle, 5 cycles after `S_STB` rose. Without the macro, no ERR ever appears.
